// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - CPU load/store request/response channel
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data-memory responder with byte/half/word access
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int         WORDS     = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  state_t      state;
  logic [3:0]  count;
  logic        lat_we;
  logic [2:0]  lat_funct3;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [31:0] mem [WORDS];

  logic                  accept;
  logic                  enter_resp;
  logic                  eff_we;
  logic [2:0]            eff_funct3;
  logic [31:0]           eff_addr;
  logic [31:0]           eff_wdata;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           rd_word;
  logic                  bad_funct3;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  req_err;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;
  logic [31:0]           load_data;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;
  logic                  wr_en;

  assign accept     = (state == IDLE) && bus.req_valid && bus.req_ready;
  assign enter_resp = ((state == WAIT) && (count == 4'd1)) || ((LATENCY == 1) && accept);

  // With LATENCY=1 the request resolves on its own accept edge, so decode the live bus in IDLE.
  assign eff_we     = (state == IDLE) ? bus.req_we     : lat_we;
  assign eff_funct3 = (state == IDLE) ? bus.req_funct3 : lat_funct3;
  assign eff_addr   = (state == IDLE) ? bus.req_addr   : lat_addr;
  assign eff_wdata  = (state == IDLE) ? bus.req_wdata  : lat_wdata;

  assign word_idx = eff_addr[DEPTH_LOG2+1:2];
  assign rd_word  = mem[word_idx];

  always_comb begin
    bad_funct3 = 1'b1;
    misaligned = 1'b0;
    case (eff_funct3)
      3'b000: bad_funct3 = 1'b0;
      3'b001: begin
        bad_funct3 = 1'b0;
        misaligned = eff_addr[0];
      end
      3'b010: begin
        bad_funct3 = 1'b0;
        misaligned = |eff_addr[1:0];
      end
      3'b100: bad_funct3 = eff_we;
      3'b101: begin
        bad_funct3 = eff_we;
        misaligned = eff_addr[0];
      end
      default: bad_funct3 = 1'b1;
    endcase
  end

  assign out_of_range = |eff_addr[31:DEPTH_LOG2+2];
  assign req_err      = bad_funct3 || misaligned || out_of_range;

  always_comb begin
    sel_byte = rd_word[7:0];
    case (eff_addr[1:0])
      2'd0: sel_byte = rd_word[7:0];
      2'd1: sel_byte = rd_word[15:8];
      2'd2: sel_byte = rd_word[23:16];
      2'd3: sel_byte = rd_word[31:24];
      default: sel_byte = rd_word[7:0];
    endcase
  end

  assign sel_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = 32'h0;
    case (eff_funct3)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, sel_byte};
      3'b101:  load_data = {16'h0, sel_half};
      default: load_data = 32'h0;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick the lanes that land.
  always_comb begin
    wr_be   = 4'b0000;
    wr_data = eff_wdata;
    case (eff_funct3)
      3'b000: begin
        wr_be   = 4'b0001 << eff_addr[1:0];
        wr_data = {4{eff_wdata[7:0]}};
      end
      3'b001: begin
        wr_be   = eff_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{eff_wdata[15:0]}};
      end
      3'b010: begin
        wr_be   = 4'b1111;
        wr_data = eff_wdata;
      end
      default: wr_be = 4'b0000;
    endcase
  end

  assign wr_en = enter_resp && eff_we && !req_err && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) begin
          mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= 4'd0;
      lat_we        <= 1'b0;
      lat_funct3    <= 3'd0;
      lat_addr      <= 32'h0;
      lat_wdata     <= 32'h0;
      bus.req_ready <= 1'b1;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= 32'h0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we        <= bus.req_we;
            lat_funct3    <= bus.req_funct3;
            lat_addr      <= bus.req_addr;
            lat_wdata     <= bus.req_wdata;
            bus.req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              count <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (count == 4'd1) begin
            state <= RESP;
          end else begin
            count <= count - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state         <= IDLE;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= 32'h0;
            bus.rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      if (enter_resp) begin
        count         <= 4'd0;
        bus.rsp_valid <= 1'b1;
        bus.rsp_err   <= req_err;
        bus.rsp_rdata <= (req_err || eff_we) ? 32'h0 : load_data;
      end
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - table, directed and randomized checks against a byte-array model
module tb_data_mem_responder;
  localparam int LAT   = 2;
  localparam int DL2   = 10;
  localparam int BYTES = 4 << DL2;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_LOG2(DL2), .LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] mm [BYTES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: byte-addressed memory, access size and sign rules from funct3.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
    int size;
    logic [31:0] val;
    logic [31:0] sh;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    err = (size == 0) || (we && f3[2]) || (addr >= 32'(BYTES));
    if (size != 0 && (addr % 32'(size)) != 0) err = 1'b1;
    rdata = 32'h0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) begin
          sh = wdata >> (8 * i);
          mm[addr + 32'(i)] = sh[7:0];
        end
      end else begin
        val = 32'h0;
        for (int i = 0; i < size; i++) val |= 32'(mm[addr + 32'(i)]) << (8 * i);
        if (!f3[2] && size < 4 && val[8*size-1]) val |= 32'hFFFF_FFFF << (8 * size);
        rdata = val;
      end
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_valid  = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({name, " accept delay"}, 32'(w), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rsp(input string name, input logic [31:0] er, input logic ee);
    int c = 1;
    while (!bus.rsp_valid && c < 40) begin
      chk({name, " ready low"}, 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      c++;
    end
    chk({name, " latency"}, 32'(c), 32'(LAT));
    chk({name, " rdata"}, bus.rsp_rdata, er);
    chk({name, " err"}, 32'(bus.rsp_err), 32'(ee));
  endtask

  task automatic hold(input string name, input int n, input logic [31:0] er, input logic ee);
    repeat (n) begin
      @(negedge clk);
      chk({name, " hold valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({name, " hold rdata"}, bus.rsp_rdata, er);
      chk({name, " hold err"}, 32'(bus.rsp_err), 32'(ee));
      chk({name, " hold ready"}, 32'(bus.req_ready), 32'd0);
    end
  endtask

  task automatic finish_rsp(input string name);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({name, " valid drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({name, " ready back"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic txn(input string name, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wdata, input int nhold,
                     input logic use_tbl, input logic [31:0] tr, input logic te);
    logic [31:0] er;
    logic ee;
    model(we, f3, addr, wdata, er, ee);
    if (use_tbl) begin
      er = tr;
      ee = te;
    end
    drive(we, f3, addr, wdata);
    wait_accept(name);
    bus.req_valid = 1'b0;
    wait_rsp(name, er, ee);
    hold(name, nhold, er, ee);
    finish_rsp(name);
  endtask

  vec_t tbl[20];
  logic [2:0] f3_pool[8];

  initial begin
    logic [31:0] e1, e2, a;
    logic e1e, e2e, we;
    logic [2:0] f3;
    int idx, r2;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.rsp_ready  = 1'b0;

    tbl[0]  = '{1'b1, 3'd2, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 3'd0, 32'h13,   32'h0,        32'hFFFFFFDE, 1'b0};
    tbl[3]  = '{1'b0, 3'd4, 32'h13,   32'h0,        32'h000000DE, 1'b0};
    tbl[4]  = '{1'b0, 3'd1, 32'h12,   32'h0,        32'hFFFFDEAD, 1'b0};
    tbl[5]  = '{1'b0, 3'd5, 32'h10,   32'h0,        32'h0000BEEF, 1'b0};
    tbl[6]  = '{1'b1, 3'd0, 32'h11,   32'h55,       32'h0,        1'b0};
    tbl[7]  = '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0};
    tbl[8]  = '{1'b0, 3'd2, 32'h12,   32'h0,        32'h0,        1'b1};
    tbl[9]  = '{1'b1, 3'd1, 32'h11,   32'hAAAA,     32'h0,        1'b1};
    tbl[10] = '{1'b0, 3'd2, 32'h1000, 32'h0,        32'h0,        1'b1};
    tbl[11] = '{1'b0, 3'd3, 32'h10,   32'h0,        32'h0,        1'b1};
    tbl[12] = '{1'b0, 3'd2, 32'h10,   32'h0,        32'hDEAD55EF, 1'b0};
    tbl[13] = '{1'b1, 3'd1, 32'h12,   32'h1234,     32'h0,        1'b0};
    tbl[14] = '{1'b0, 3'd2, 32'h10,   32'h0,        32'h123455EF, 1'b0};
    tbl[15] = '{1'b1, 3'd4, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[16] = '{1'b0, 3'd5, 32'h12,   32'h0,        32'h00001234, 1'b0};
    tbl[17] = '{1'b1, 3'd2, 32'hFFC,  32'hCAFEF00D, 32'h0,        1'b0};
    tbl[18] = '{1'b0, 3'd2, 32'hFFC,  32'h0,        32'hCAFEF00D, 1'b0};
    tbl[19] = '{1'b0, 3'd0, 32'hFFF,  32'h0,        32'hFFFFFFCA, 1'b0};

    f3_pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    @(negedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(bus.rsp_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int w = 0; w < 64; w++) txn("preload", 1'b1, 3'd2, 32'(w * 4), $urandom, 0, 1'b0, 32'h0, 1'b0);

    for (int i = 0; i < 20; i++) txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].f3, tbl[i].addr,
                                     tbl[i].wdata, i % 3, 1'b1, tbl[i].rdata, tbl[i].err);

    // Response held off for 5 cycles while the next request waits on the bus.
    model(1'b0, 3'd2, 32'h10, 32'h0, e1, e1e);
    model(1'b0, 3'd5, 32'h12, 32'h0, e2, e2e);
    drive(1'b0, 3'd2, 32'h10, 32'h0);
    wait_accept("stall first");
    drive(1'b0, 3'd5, 32'h12, 32'h0);
    wait_rsp("stall first", e1, e1e);
    hold("stall first", 5, e1, e1e);
    finish_rsp("stall first");
    wait_accept("stall second");
    bus.req_valid = 1'b0;
    wait_rsp("stall second", e2, e2e);
    finish_rsp("stall second");

    // Reset while a store is waiting: store must be dropped.
    drive(1'b1, 3'd2, 32'h20, 32'h12345678);
    wait_accept("abort");
    bus.req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("abort rsp_err", 32'(bus.rsp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    txn("after abort", 1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b0, 32'h0, 1'b0);

    for (int k = 0; k < 300; k++) begin
      we  = 1'($urandom_range(0, 1));
      idx = int'($urandom_range(0, 19));
      f3  = (idx < 17) ? f3_pool[idx % 5] : f3_pool[idx - 12];
      a   = 32'($urandom_range(0, 255));
      r2  = int'($urandom_range(0, 9));
      if (r2 < 5) a = a & 32'hFFFF_FFFC;
      else if (r2 == 9) a = a | (32'h1 << $urandom_range(12, 31));
      txn("rand", we, f3, a, $urandom, int'($urandom_range(0, 2)), 1'b0, 32'h0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d miscompares so far", n_miss);
    $fatal(1, "timeout");
  end
endmodule
